// File: rtl/mac_bram_sequencer.sv
// Sequencer for a BRAM-fed MAC: walks operand addresses, waits out the registered BRAM read,
// captures each result into a result BRAM and keeps a wide running sum of all results.
module mac_bram_sequencer #(
  parameter int unsigned AddrW = 8,
  parameter int unsigned ResW  = 50,
  parameter int unsigned AccW  = 58
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [AddrW-1:0] len_i,
  input  logic [AddrW-1:0] rd_base_i,
  input  logic [AddrW-1:0] wr_base_i,
  input  logic [ResW-1:0]  mac_result_i,
  output logic [AddrW-1:0] rd_addr_o,
  output logic             wr_en_o,
  output logic [AddrW-1:0] wr_addr_o,
  output logic [15:0]      wr_data_o,
  output logic [AccW-1:0]  acc_out_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {StIdle, StWait, StCapt} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] rd_addr_q, rd_addr_d;
  logic [AddrW-1:0] idx_q, idx_d;
  logic [AddrW-1:0] len_q, len_d;
  logic [AddrW-1:0] wr_base_q, wr_base_d;
  logic [AddrW-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]      wr_data_q, wr_data_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    idx_d     = idx_q;
    len_d     = len_q;
    wr_base_d = wr_base_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          acc_d = '0;
          if (len_i != '0) begin
            rd_addr_d = rd_base_i;
            idx_d     = '0;
            len_d     = len_i;
            wr_base_d = wr_base_i;
            busy_d    = 1'b1;
            state_d   = StWait;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      // Operand BRAMs register their outputs on this edge.
      StWait: state_d = StCapt;
      StCapt: begin
        acc_d     = acc_q + AccW'(mac_result_i);
        wr_en_d   = 1'b1;
        wr_addr_d = wr_base_q + idx_q;
        wr_data_d = mac_result_i[15:0];
        if (idx_q == len_q - AddrW'(1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          idx_d     = idx_q + AddrW'(1);
          rd_addr_d = rd_addr_q + AddrW'(1);
          state_d   = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      rd_addr_q <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      wr_base_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      wr_base_q <= wr_base_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_addr_o = rd_addr_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign acc_out_o = acc_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_mac_bram_sequencer.sv
// Bench for mac_bram_sequencer: six operand BRAM models with registered read feed a MAC model;
// each run is checked against a list of expected writes and a sum computed from the BRAM contents.
module tb_mac_bram_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0, rd_base = '0, wr_base = '0;
  logic [49:0] mac_result;
  logic [7:0]  rd_addr, wr_addr;
  logic        wr_en, busy, done;
  logic [15:0] wr_data;
  logic [57:0] acc_out;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  bram [6][256];
  logic [7:0]  q [6];
  logic [7:0]  wq_addr [$];
  logic [15:0] wq_data [$];
  int          done_cnt = 0;

  mac_bram_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start),
    .len_i        (len),
    .rd_base_i    (rd_base),
    .wr_base_i    (wr_base),
    .mac_result_i (mac_result),
    .rd_addr_o    (rd_addr),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .acc_out_o    (acc_out),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  // MAC datapath model: combinational function of the six operands.
  function automatic logic [49:0] mac_of(input logic [7:0] a1, b1, a2, b2, a3, b3);
    longint unsigned p, s;
    p = longint'(a1) * b1 + longint'(a2) * b2 + longint'(a3) * b3;
    s = longint'(a1) * b1 + longint'(a2) * b2 + longint'(a1);
    return 50'(p * s);
  endfunction

  function automatic logic [49:0] mac_at(input logic [7:0] a);
    return mac_of(bram[0][a], bram[1][a], bram[2][a], bram[3][a], bram[4][a], bram[5][a]);
  endfunction

  always @(posedge clk) for (int j = 0; j < 6; j++) q[j] <= bram[j][rd_addr];
  assign mac_result = mac_of(q[0], q[1], q[2], q[3], q[4], q[5]);

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int j = 0; j < 6; j++)
      for (int a = 0; a < 256; a++) bram[j][a] = 8'($urandom);
  endtask

  task automatic run(input logic [7:0] rb, wb, n, input bit repulse);
    int e;
    bit seen;
    logic [57:0] exp_acc;
    logic [7:0] a;
    wq_addr.delete();
    wq_data.delete();
    @(negedge clk);
    start = 1'b1; rd_base = rb; wr_base = wb; len = n;
    @(negedge clk);
    start = 1'b0;
    rd_base = 8'($urandom); wr_base = 8'($urandom); len = 8'($urandom);
    e = 0;
    seen = 1'b0;
    while (!seen && e <= 2 * int'(n) + 4) begin
      if (e == 0 && n != 0) check("busy_after_start", 64'(busy), 64'd1);
      if (e % 2 == 0 && e < 2 * int'(n)) check("rd_addr_seq", 64'(rd_addr), 64'(8'(rb + e / 2)));
      if (done) begin
        seen = 1'b1;
        check("done_time", 64'(e), (n == 0) ? 64'd0 : 64'(2 * int'(n)));
        check("busy_at_done", 64'(busy), 64'd0);
      end
      if (repulse && e == 2) start = 1'b1;
      if (repulse && e == 3) start = 1'b0;
      if (!seen) begin
        @(negedge clk);
        e++;
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("write_count", 64'(wq_addr.size()), 64'(n));
    exp_acc = '0;
    for (int k = 0; k < int'(n); k++) begin
      a = 8'(rb + k);
      exp_acc += 58'(mac_at(a));
      if (k < wq_addr.size()) begin
        check("wr_addr", 64'(wq_addr[k]), 64'(8'(wb + k)));
        check("wr_data", 64'(wq_data[k]), 64'(mac_at(a) & 50'hffff));
      end
    end
    check("acc_out", 64'(acc_out), 64'(exp_acc));
  endtask

  initial begin
    int dc, w;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_acc", 64'(acc_out), 64'd0);
    check("rst_flags", 64'({wr_en, busy, done}), 64'd0);
    fill_random();
    for (int a = 1; a <= 3; a++)
      for (int j = 0; j < 6; j++) bram[j][a] = 8'(j + 1);
    @(negedge clk);
    rst_ni = 1'b1;

    run(8'd1, 8'h10, 8'd1, 1'b0);
    check("single_data", 64'(wq_data[0]), 64'h0294);
    check("single_acc", 64'(acc_out), 64'd660);
    run(8'd1, 8'h10, 8'd3, 1'b0);
    check("three_acc", 64'(acc_out), 64'd1980);
    check("three_last_addr", 64'(wq_addr[2]), 64'h12);

    run(8'd254, 8'd255, 8'd3, 1'b0);
    check("wrap_addr0", 64'(wq_addr[0]), 64'd255);
    check("wrap_addr1", 64'(wq_addr[1]), 64'd0);
    check("wrap_addr2", 64'(wq_addr[2]), 64'd1);

    run(8'd7, 8'd9, 8'd0, 1'b0);
    check("empty_acc", 64'(acc_out), 64'd0);
    run(8'd20, 8'd40, 8'd3, 1'b1);

    for (int i = 0; i < 6; i++) begin
      fill_random();
      run(8'($urandom), 8'($urandom), 8'($urandom_range(1, 20)), 1'b0);
    end

    for (int j = 0; j < 6; j++)
      for (int a = 0; a < 256; a++) bram[j][a] = 8'd255;
    run(8'd0, 8'd0, 8'd255, 1'b0);
    check("max_acc", 64'(acc_out), 64'd6481908208125);
    check("max_data", 64'(wq_data[254]), 64'(50'd25419247875 & 50'hffff));

    fill_random();
    wq_addr.delete();
    wq_data.delete();
    @(negedge clk);
    start = 1'b1; rd_base = 8'd30; wr_base = 8'd60; len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (wq_addr.size() < 2 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("reset_wait_writes", 64'(wq_addr.size()), 64'd2);
    dc = done_cnt;
    #1 rst_ni = 1'b0;
    #1;
    check("midrst_rd_addr", 64'(rd_addr), 64'd0);
    check("midrst_wr", 64'({wr_addr, wr_data}), 64'd0);
    check("midrst_acc", 64'(acc_out), 64'd0);
    check("midrst_flags", 64'({wr_en, busy, done}), 64'd0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt), 64'(dc));
    check("midrst_no_writes", 64'(wq_addr.size()), 64'd2);
    run(8'd30, 8'd60, 8'd5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
